// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv : multi-cycle RISC-V M-extension execute unit (EX stage)
//
// Sits beside the single-cycle ALU. The unit holds the pipeline through
// stallreq_o while an operation iterates. It then pulses done_o for one cycle,
// together with the registered result and the destination register.
//   - Divide : radix-2 restoring, one quotient bit per cycle.
//   - Multiply: shift-add, one multiplier bit per cycle.
//   - Divide-by-zero and signed overflow resolve in one cycle.
//
// Build option: define MULDIV_FAST_MUL_EN to compute all multiplies with a
// single-cycle '*' product. In that build the iterative multiply datapath is
// not built.
//
// Parameters:
//   XLEN   operand/result width (even, >= 8)
//   CNT_W  iteration counter width
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   start_i    in   M-op present in EX (held high while stalled)
//   funct3_i   in   operation select (MUL..REMU)
//   src1/src2  in   rs1 / rs2 operands
//   rd/rd_op   in   destination register and its write enable
//   flush_i    in   abort current operation
//   stallreq_o out  combinational pipeline hold
//   done_o     out  one-cycle result-valid pulse
//   result_o   out  registered result
//   rd_o       out  registered destination register
//   rd_op_o    out  registered write enable, high only with done_o
// ---------------------------------------------------------------------------
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      rd,
    input  logic            rd_op,
    input  logic            flush_i,
    output logic            stallreq_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            rd_op_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [XLEN-1:0]   ZERO_X = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(XLEN - 1);

    // Two's-complement negate when n is set
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + ONE_X) : v;
    endfunction

    logic [1:0]       state_r;
    logic [CNT_W-1:0] count_r;
    logic             done_r;
    logic             rd_op_out_r;
    logic             rd_op_cap_r;
    logic [4:0]       rd_r;
    logic [XLEN-1:0]  result_r;
    logic             res_neg_r;
    logic             is_rem_r;

    // Divider state: partial remainder, dividend/quotient shift register, divisor
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  dvsr_r;

    // Operand decode and fast-path signals
    logic             is_div_s;
    logic             op1_signed_s;
    logic             op2_signed_s;
    logic             neg1_s;
    logic             neg2_s;
    logic [XLEN-1:0]  abs1_s;
    logic [XLEN-1:0]  abs2_s;
    logic             res_neg_s;
    logic             dz_s;
    logic             ovf_s;
    logic             fast_s;
    logic [XLEN-1:0]  fast_res_s;

    // Iteration signals
    logic [XLEN:0]    rem_shift_s;
    logic [XLEN:0]    diff_s;
    logic             q_bit_s;
    logic [XLEN-1:0]  rem_nxt_s;
    logic [XLEN-1:0]  quo_nxt_s;
    logic [XLEN-1:0]  div_res_s;
    logic [XLEN-1:0]  iter_res_s;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fprod_s;
`else
    localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};
    logic              is_mul_r;
    logic              mul_hi_r;
    logic [2*XLEN-1:0] acc_r;
    logic [2*XLEN-1:0] mcand_r;
    logic [XLEN-1:0]   mplier_r;
    logic [2*XLEN-1:0] acc_nxt_s;
    logic [2*XLEN-1:0] prod_fin_s;
    logic [XLEN-1:0]   mul_res_s;
`endif

    // Pipeline hold: DONE never stalls because start_i still belongs to the finished op
    assign stallreq_o = start_i & (state_r != ST_DONE) & ~flush_i & ~RST;
    assign done_o     = done_r;
    assign rd_op_o    = rd_op_out_r;
    assign rd_o       = rd_r;
    assign result_o   = result_r;

    // Operand sign handling and single-cycle (fast path) results
    always_comb begin
        is_div_s = funct3_i[2];
        if (is_div_s) begin
            op1_signed_s = ~funct3_i[0];
            op2_signed_s = ~funct3_i[0];
        end else begin
            // MUL low bits are sign-agnostic, so it is treated like MULH
            op1_signed_s = (funct3_i[1:0] != 2'b11);
            op2_signed_s = ~funct3_i[1];
        end
        neg1_s = op1_signed_s & src1[XLEN-1];
        neg2_s = op2_signed_s & src2[XLEN-1];
        abs1_s = neg_if(src1, neg1_s);
        abs2_s = neg_if(src2, neg2_s);
        // Remainder takes the dividend's sign; everything else takes the XOR
        if (is_div_s && funct3_i[1]) begin
            res_neg_s = neg1_s;
        end else begin
            res_neg_s = neg1_s ^ neg2_s;
        end
        dz_s  = is_div_s & (src2 == ZERO_X);
        ovf_s = is_div_s & ~funct3_i[0] & (src1 == MIN_X) & (src2 == ONES_X);
`ifdef MULDIV_FAST_MUL_EN
        fprod_s = {{XLEN{neg1_s}}, src1} * {{XLEN{neg2_s}}, src2};
        fast_s  = is_div_s ? (dz_s | ovf_s) : 1'b1;
`else
        fast_s  = is_div_s & (dz_s | ovf_s);
`endif
        if (dz_s) begin
            fast_res_s = funct3_i[1] ? src1 : ONES_X;
        end else if (ovf_s) begin
            fast_res_s = funct3_i[1] ? ZERO_X : src1;
`ifdef MULDIV_FAST_MUL_EN
        end else if (!is_div_s) begin
            fast_res_s = (funct3_i[1:0] == 2'b00) ? fprod_s[XLEN-1:0] : fprod_s[2*XLEN-1:XLEN];
`endif
        end else begin
            fast_res_s = ZERO_X;
        end
    end

    // One restoring-divide / shift-add-multiply step plus final sign correction
    always_comb begin
        rem_shift_s = {rem_r, quo_r[XLEN-1]};
        diff_s      = rem_shift_s - {1'b0, dvsr_r};
        q_bit_s     = ~diff_s[XLEN];
        rem_nxt_s   = q_bit_s ? diff_s[XLEN-1:0] : rem_shift_s[XLEN-1:0];
        quo_nxt_s   = {quo_r[XLEN-2:0], q_bit_s};
        div_res_s   = is_rem_r ? neg_if(rem_nxt_s, res_neg_r) : neg_if(quo_nxt_s, res_neg_r);
`ifdef MULDIV_FAST_MUL_EN
        iter_res_s  = div_res_s;
`else
        acc_nxt_s   = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        prod_fin_s  = res_neg_r ? (~acc_nxt_s + ONE_2X) : acc_nxt_s;
        mul_res_s   = mul_hi_r ? prod_fin_s[2*XLEN-1:XLEN] : prod_fin_s[XLEN-1:0];
        iter_res_s  = is_mul_r ? mul_res_s : div_res_s;
`endif
    end

    // Control FSM and datapath registers (priority: RST > flush_i > start_i)
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            count_r     <= {CNT_W{1'b0}};
            done_r      <= 1'b0;
            rd_op_out_r <= 1'b0;
            rd_op_cap_r <= 1'b0;
            rd_r        <= 5'd0;
            result_r    <= ZERO_X;
            res_neg_r   <= 1'b0;
            is_rem_r    <= 1'b0;
            rem_r       <= ZERO_X;
            quo_r       <= ZERO_X;
            dvsr_r      <= ZERO_X;
`ifndef MULDIV_FAST_MUL_EN
            is_mul_r    <= 1'b0;
            mul_hi_r    <= 1'b0;
            acc_r       <= {(2*XLEN){1'b0}};
            mcand_r     <= {(2*XLEN){1'b0}};
            mplier_r    <= ZERO_X;
`endif
        end else if (flush_i) begin
            // result_o deliberately keeps its last value
            state_r     <= ST_IDLE;
            count_r     <= {CNT_W{1'b0}};
            done_r      <= 1'b0;
            rd_op_out_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r      <= 1'b0;
                    rd_op_out_r <= 1'b0;
                    if (start_i) begin
                        rd_r        <= rd;
                        rd_op_cap_r <= rd_op;
                        if (fast_s) begin
                            result_r    <= fast_res_s;
                            done_r      <= 1'b1;
                            rd_op_out_r <= rd_op;
                            state_r     <= ST_DONE;
                        end else begin
                            res_neg_r <= res_neg_s;
                            is_rem_r  <= funct3_i[1];
                            rem_r     <= ZERO_X;
                            quo_r     <= abs1_s;
                            dvsr_r    <= abs2_s;
`ifndef MULDIV_FAST_MUL_EN
                            is_mul_r  <= ~funct3_i[2];
                            mul_hi_r  <= (funct3_i[1:0] != 2'b00);
                            acc_r     <= {(2*XLEN){1'b0}};
                            mcand_r   <= {ZERO_X, abs1_s};
                            mplier_r  <= abs2_s;
`endif
                            count_r   <= {CNT_W{1'b0}};
                            state_r   <= ST_BUSY;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    rem_r    <= rem_nxt_s;
                    quo_r    <= quo_nxt_s;
`ifndef MULDIV_FAST_MUL_EN
                    acc_r    <= acc_nxt_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
`endif
                    count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_r == LAST_CNT) begin
                        result_r    <= iter_res_s;
                        done_r      <= 1'b1;
                        rd_op_out_r <= rd_op_cap_r;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    done_r      <= 1'b0;
                    rd_op_out_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    done_r      <= 1'b0;
                    rd_op_out_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
`timescale 1ns/1ps
module tb_ex_muldiv;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FASTMUL = 1'b1;
`else
    localparam bit FASTMUL = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST;
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [4:0]      rd;
    logic            rd_op;
    logic            flush_i;
    logic            stallreq_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;
    logic            rd_op_o;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RST(RST), .start_i(start_i), .funct3_i(funct3_i),
        .src1(src1), .src2(src2), .rd(rd), .rd_op(rd_op), .flush_i(flush_i),
        .stallreq_o(stallreq_o), .done_o(done_o), .result_o(result_o),
        .rd_o(rd_o), .rd_op_o(rd_op_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          one_cyc;  // divide special case (zero divisor / overflow)
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rd_op;
    } sb_t;

    localparam int NV = 22;
    vec_t tbl [NV];
    sb_t  sbq [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every done_o pulse must match the oldest pending op
    always @(negedge CLK) begin
        sb_t e;
        if (rd_op_o && !done_o) begin
            n_vec++;
            n_err++;
            $display("FAIL rd_op_without_done: actual rd_op_o=1 done_o=0 required rd_op_o=0");
        end
        if (done_o) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: actual done_o=1 result=%0h required no pulse", result_o);
            end else begin
                e = sbq.pop_front();
                chk("result", result_o, e.res);
                chk("rd_o", {27'd0, rd_o}, {27'd0, e.rd});
                chk("rd_op_o", {31'd0, rd_op_o}, {31'd0, e.rd_op});
            end
        end
    end

    // Drive one op, push its expectation, measure latency and stall cycles
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic [4:0] r, input logic rop,
                          input int lat, input bit hold);
        int  edges  = 0;
        int  stalls = 0;
        bit  got    = 1'b0;
        sb_t e;
        @(negedge CLK);
        start_i  = 1'b1;
        funct3_i = f3;
        src1     = a;
        src2     = b;
        rd       = r;
        rd_op    = rop;
        e.res = exp; e.rd = r; e.rd_op = rop;
        sbq.push_back(e);
        #1;
        if (stallreq_o) stalls++;
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge CLK);
            edges++;
            @(negedge CLK);
            if (done_o) got = 1'b1;
            else if (stallreq_o) stalls++;
        end
        chk("latency", edges, lat);
        chk("stall_cycles", stalls, lat);
        if (!hold) start_i = 1'b0;
    endtask

    function automatic int lat_of(input vec_t v);
        if (v.one_cyc) return 1;
        if (!v.f3[2] && FASTMUL) return 1;
        return XLEN + 1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        tbl[1]  = '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        tbl[2]  = '{3'b001, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, 1'b0};
        tbl[3]  = '{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        tbl[4]  = '{3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 1'b0};
        tbl[5]  = '{3'b000, 32'h00010000,  32'h00010000, 32'h00000000, 1'b0};
        tbl[6]  = '{3'b011, 32'h00010000,  32'h00010000, 32'h00000001, 1'b0};
        tbl[7]  = '{3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0};
        tbl[8]  = '{3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 1'b0};
        tbl[9]  = '{3'b101, 32'd100,       32'd7,        32'd14,       1'b0};
        tbl[10] = '{3'b111, 32'd100,       32'd7,        32'd2,        1'b0};
        tbl[11] = '{3'b101, 32'h1234,      32'd0,        32'hFFFFFFFF, 1'b1};
        tbl[12] = '{3'b111, 32'h1234,      32'd0,        32'h1234,     1'b1};
        tbl[13] = '{3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1};
        tbl[14] = '{3'b110, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1'b1};
        tbl[15] = '{3'b100, 32'h7FFFFFFF,  32'hFFFFFFFF, 32'h80000001, 1'b0};
        tbl[16] = '{3'b110, 32'd7,         32'hFFFFFFFE, 32'd1,        1'b0};
        tbl[17] = '{3'b100, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFFF, 1'b1};
        tbl[18] = '{3'b110, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFF9, 1'b1};
        tbl[19] = '{3'b010, 32'd2,         32'hFFFFFFFF, 32'd1,        1'b0};
        tbl[20] = '{3'b101, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 1'b0};
        tbl[21] = '{3'b000, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,        1'b0};

        // Reset with start_i high: nothing may be accepted or stalled
        RST = 1'b1; start_i = 1'b1; flush_i = 1'b0; funct3_i = 3'b100;
        src1 = 32'd5; src2 = 32'd3; rd = 5'd3; rd_op = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_result", result_o, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_rd", {27'd0, rd_o}, 32'd0);
        chk("rst_rd_op", {31'd0, rd_op_o}, 32'd0);
        chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
        RST = 1'b0;
        start_i = 1'b0;

        // Table: mostly back-to-back with start_i held, some with a gap
        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, 5'(i + 1), i[0],
                   lat_of(tbl[i]), (i % 4) != 3 && i != NV - 1);
        end

        // Flush at BUSY count 10: no done, no stall in the flush cycle
        @(negedge CLK);
        start_i = 1'b1; funct3_i = 3'b100; src1 = 32'd1000; src2 = 32'd3;
        rd = 5'd9; rd_op = 1'b1;
        @(posedge CLK);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        flush_i = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stallreq_o}, 32'd0);
        chk("flush_done", {31'd0, done_o}, 32'd0);
        chk("flush_rd_op", {31'd0, rd_op_o}, 32'd0);
        @(posedge CLK);
        #1;
        flush_i = 1'b0;
        chk("flush_result_hold", result_o, tbl[NV-1].exp);
        chk("post_flush_done", {31'd0, done_o}, 32'd0);
        run_op(3'b111, 32'd9, 32'd4, 32'd1, 5'd10, 1'b1, XLEN + 1, 1'b0);

        // Reset in the middle of BUSY: clears immediately, no result pulse
        @(negedge CLK);
        start_i = 1'b1; funct3_i = 3'b101; src1 = 32'd50; src2 = 32'd5;
        rd = 5'd11; rd_op = 1'b1;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("busy_rst_done", {31'd0, done_o}, 32'd0);
        chk("busy_rst_result", result_o, 32'd0);
        chk("busy_rst_rd", {27'd0, rd_o}, 32'd0);
        chk("busy_rst_stall", {31'd0, stallreq_o}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        start_i = 1'b0;
        run_op(3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 5'd12, 1'b1, XLEN + 1, 1'b1);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd13, 1'b0,
               FASTMUL ? 1 : XLEN + 1, 1'b0);

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
